// File: rtl/data_mem_stage_if.sv
// Bundle of request, control and completion signals between the execute
// stage (master) and the data-memory stage (slave).
interface data_mem_stage_if;
  // request side
  logic        Valid;
  logic [63:0] ALUResult;
  logic [63:0] WriteData;
  logic [2:0]  Funct3;
  logic [4:0]  Rd;
  logic        BranchTaken;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  // completion side
  logic        Stall;
  logic        ValidOut;
  logic [63:0] ReadData;
  logic [63:0] ALUResultOut;
  logic [4:0]  RdOut;
  logic        BranchTakenOut;
  logic        MemtoRegOut;
  logic        RegWriteOut;
  logic        Misaligned;

  modport master (
    output Valid, ALUResult, WriteData, Funct3, Rd,
           BranchTaken, MemRead, MemWrite, MemtoReg, RegWrite,
    input  Stall, ValidOut, ReadData, ALUResultOut, RdOut,
           BranchTakenOut, MemtoRegOut, RegWriteOut, Misaligned
  );

  modport slave (
    input  Valid, ALUResult, WriteData, Funct3, Rd,
           BranchTaken, MemRead, MemWrite, MemtoReg, RegWrite,
    output Stall, ValidOut, ReadData, ALUResultOut, RdOut,
           BranchTakenOut, MemtoRegOut, RegWriteOut, Misaligned
  );
endinterface

// File: rtl/data_mem_stage.sv
// RV64 data-memory pipeline stage: byte-addressed little-endian data array of
// DEPTH doublewords, sized/sign-extended loads, byte-masked stores and an
// optional fixed number of wait states per memory access.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, accesses not
// aligned to their size complete with Misaligned=1 and have no effect;
// otherwise low address bits are simply aligned down.
module data_mem_stage #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic reset,
  data_mem_stage_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        branch_taken;
    logic        mem_read;
    logic        mem_write;
    logic        memto_reg;
    logic        reg_write;
  } req_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  req_t        req_in, req_reg, req_cur;
  logic        accept, complete;

  logic [2:0]    lane_raw, align_mask, lane;
  logic [7:0]    size_mask, byte_en;
  logic [AW-1:0] idx;
  logic          in_range, no_access, trap, access_ok, do_write;
  logic [63:0]   wdata_shift, mem_word, shifted, load_ext, load_value;

  logic        valid_out_reg;
  logic [63:0] read_data_reg, alu_result_out_reg;
  logic [4:0]  rd_out_reg;
  logic        branch_taken_out_reg, memto_reg_out_reg, reg_write_out_reg;
  logic        misaligned_reg;

  // Collect the incoming request into one record
  always_comb begin
    req_in.addr         = bus.ALUResult;
    req_in.wdata        = bus.WriteData;
    req_in.funct3       = bus.Funct3;
    req_in.rd           = bus.Rd;
    req_in.branch_taken = bus.BranchTaken;
    req_in.mem_read     = bus.MemRead;
    req_in.mem_write    = bus.MemWrite;
    req_in.memto_reg    = bus.MemtoReg;
    req_in.reg_write    = bus.RegWrite;
  end

  // In IDLE the live inputs are serviced; in WAIT the latched copy is
  assign req_cur = (state_reg == S_IDLE) ? req_in : req_reg;

  // FSM state and wait counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, complete at count 1
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (bus.Valid) begin
          accept = 1'b1;
          if ((req_in.mem_read || req_in.mem_write) && (WAIT_STATES != 0)) begin
            state_next = S_WAIT;
            count_next = WAIT_LOAD;
          end else begin
            complete = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (count_reg == 4'd1) begin
          complete   = 1'b1;
          state_next = S_IDLE;
          count_next = '0;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Hold the accepted request for the duration of the wait states
  always_ff @(posedge clk) begin
    if (reset) begin
      req_reg <= '0;
    end else if (accept) begin
      req_reg <= req_in;
    end
  end

  // Address decode: size, lane alignment, range and access legality
  always_comb begin
    lane_raw   = req_cur.addr[2:0];
    idx        = req_cur.addr[AW+2:3];
    in_range   = (req_cur.addr[63:AW+3] == '0);
    no_access  = (req_cur.funct3 == 3'b111);
    align_mask = 3'b111;
    size_mask  = 8'h01;
    case (req_cur.funct3[1:0])
      2'b00: begin align_mask = 3'b111; size_mask = 8'h01; end
      2'b01: begin align_mask = 3'b110; size_mask = 8'h03; end
      2'b10: begin align_mask = 3'b100; size_mask = 8'h0F; end
      default: begin align_mask = 3'b000; size_mask = 8'hFF; end
    endcase
    lane = lane_raw & align_mask;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = (|(lane_raw & ~align_mask)) && (req_cur.mem_read || req_cur.mem_write)
           && !no_access;
`else
    trap = 1'b0;
`endif
    access_ok   = in_range && !no_access && !trap;
    byte_en     = size_mask << lane;
    wdata_shift = req_cur.wdata << {lane, 3'b000};
    do_write    = complete && req_cur.mem_write && access_ok;
  end

  // One byte-wide array per lane so each store touches only its own bytes
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Byte-lane storage: cleared on reset, written at completion
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) lane_mem[i] <= '0;
        end else if (do_write && byte_en[gi]) begin
          lane_mem[idx] <= wdata_shift[gi*8 +: 8];
        end
      end

      assign mem_word[gi*8 +: 8] = lane_mem[idx];
    end
  endgenerate

  // Right-align the addressed bytes and extend according to Funct3
  always_comb begin
    shifted  = mem_word >> {lane, 3'b000};
    load_ext = '0;
    case (req_cur.funct3)
      3'b000:  load_ext = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_ext = shifted;
      3'b100:  load_ext = {56'd0, shifted[7:0]};
      3'b101:  load_ext = {48'd0, shifted[15:0]};
      3'b110:  load_ext = {32'd0, shifted[31:0]};
      default: load_ext = '0;
    endcase
    // Stores (including read+write) and illegal accesses return zero
    load_value = (req_cur.mem_read && !req_cur.mem_write && access_ok) ? load_ext : '0;
  end

  // Completion registers: all update together, ValidOut pulses once
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out_reg        <= 1'b0;
      read_data_reg        <= '0;
      alu_result_out_reg   <= '0;
      rd_out_reg           <= '0;
      branch_taken_out_reg <= 1'b0;
      memto_reg_out_reg    <= 1'b0;
      reg_write_out_reg    <= 1'b0;
      misaligned_reg       <= 1'b0;
    end else begin
      valid_out_reg <= complete;
      if (complete) begin
        read_data_reg        <= load_value;
        alu_result_out_reg   <= req_cur.addr;
        rd_out_reg           <= req_cur.rd;
        branch_taken_out_reg <= req_cur.branch_taken;
        memto_reg_out_reg    <= req_cur.memto_reg;
        reg_write_out_reg    <= req_cur.reg_write && !trap;
        misaligned_reg       <= trap;
      end
    end
  end

  assign bus.Stall          = (state_reg == S_WAIT);
  assign bus.ValidOut       = valid_out_reg;
  assign bus.ReadData       = read_data_reg;
  assign bus.ALUResultOut   = alu_result_out_reg;
  assign bus.RdOut          = rd_out_reg;
  assign bus.BranchTakenOut = branch_taken_out_reg;
  assign bus.MemtoRegOut    = memto_reg_out_reg;
  assign bus.RegWriteOut    = reg_write_out_reg;
`ifdef MEM_MISALIGN_TRAP_EN
  assign bus.Misaligned     = misaligned_reg;
`else
  assign bus.Misaligned     = 1'b0;
`endif

endmodule
